// File: rtl/count_sched_pkg.sv
// Shared types and widths for the count_sched time-division countdown scheduler.
package count_sched_pkg;

  function automatic int calc_chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CountWidth = 8;
  localparam int NCH        = 4;
  localparam int CHW        = calc_chw(NCH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [CHW-1:0]        tag;
    logic [CountWidth-1:0] value;
  } stage_entry_t;

endpackage

// File: rtl/count_dec_stage.sv
// Shared registered decrement stage: captures count-1 with its channel tag; a
// same-channel invalidate kills the entry both at capture and at writeback.
module count_dec_stage
  import count_sched_pkg::*;
(
  input  logic                  iClk,
  input  logic                  _iRst,
  input  logic                  i_issue,
  input  logic [CHW-1:0]        i_tag,
  input  logic [CountWidth-1:0] i_count,
  input  logic                  i_inv,
  input  logic [CHW-1:0]        i_inv_tag,
  output stage_entry_t          o_wb
);

  stage_entry_t r_entry;
  logic         w_cap_valid;

  assign w_cap_valid = i_issue && !(i_inv && (i_inv_tag == i_tag));

  always_ff @(posedge iClk or negedge _iRst) begin
    if (!_iRst) begin
      r_entry <= '0;
    end else begin
      r_entry.valid <= w_cap_valid;
      r_entry.tag   <= i_tag;
      r_entry.value <= i_count - CountWidth'(1);
    end
  end

  always_comb begin
    o_wb       = r_entry;
    o_wb.valid = r_entry.valid && !(i_inv && (i_inv_tag == r_entry.tag));
  end

endmodule

// File: rtl/count_sched.sv
// count_sched: NCH countdown channels sharing one decrement stage by slot.
// Optional abort input enabled by defining COUNT_SCHED_ABORT_EN.
//
// state   | meaning
// ST_IDLE | channel stopped, count held
// ST_RUN  | channel decremented once per slot round
module count_sched
  import count_sched_pkg::*;
(
  input  logic                  iClk,
  input  logic                  _iRst,
  input  logic                  _iLoad,
  input  logic [CHW-1:0]        iLoadCh,
  input  logic [CountWidth-1:0] iLoadVal,
`ifdef COUNT_SCHED_ABORT_EN
  input  logic                  _iAbort,
`endif
  input  logic                  _iHold,
  input  logic [CHW-1:0]        iRdCh,
  output logic [CountWidth-1:0] oRdCount,
  output logic [NCH-1:0]        oBusy,
  output logic [NCH-1:0]        oDone,
  output logic [CHW-1:0]        oSlot
);

  ch_state_e             r_state     [NCH];
  ch_state_e             w_state_nxt [NCH];
  logic [CountWidth-1:0] r_count     [NCH];
  logic [CountWidth-1:0] w_count_nxt [NCH];
  logic [NCH-1:0]        r_done;
  logic [NCH-1:0]        w_done_nxt;
  logic [CHW-1:0]        r_slot;

  logic                  w_load;
  logic                  w_abort;
  logic                  w_kill;
  logic                  w_issue;
  stage_entry_t          w_wb;

  assign w_load = !_iLoad;
`ifdef COUNT_SCHED_ABORT_EN
  assign w_abort = _iLoad && !_iAbort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_kill  = w_load || w_abort;
  assign w_issue = _iHold && (r_state[r_slot] == ST_RUN);

  count_dec_stage u_stage (
    .iClk      (iClk),
    ._iRst     (_iRst),
    .i_issue   (w_issue),
    .i_tag     (r_slot),
    .i_count   (r_count[r_slot]),
    .i_inv     (w_kill),
    .i_inv_tag (iLoadCh),
    .o_wb      (w_wb)
  );

  // Load/abort are applied after writeback so they always win on the same channel.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_state_nxt[c] = r_state[c];
      w_count_nxt[c] = r_count[c];
    end
    w_done_nxt = '0;

    if (w_wb.valid) begin
      w_count_nxt[w_wb.tag] = w_wb.value;
      if (w_wb.value == '0) begin
        w_state_nxt[w_wb.tag] = ST_IDLE;
        w_done_nxt[w_wb.tag]  = 1'b1;
      end
    end

    if (w_load) begin
      w_count_nxt[iLoadCh] = iLoadVal;
      if (iLoadVal == '0) begin
        w_state_nxt[iLoadCh] = ST_IDLE;
        w_done_nxt[iLoadCh]  = 1'b1;
      end else begin
        w_state_nxt[iLoadCh] = ST_RUN;
        w_done_nxt[iLoadCh]  = 1'b0;
      end
    end else if (w_abort) begin
      w_state_nxt[iLoadCh] = ST_IDLE;
      w_done_nxt[iLoadCh]  = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge _iRst) begin
    if (!_iRst) begin
      for (int c = 0; c < NCH; c++) begin
        r_state[c] <= ST_IDLE;
        r_count[c] <= '0;
      end
      r_done <= '0;
      r_slot <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_count[c] <= w_count_nxt[c];
      end
      r_done <= w_done_nxt;
      if (_iHold) r_slot <= r_slot + CHW'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) oBusy[c] = (r_state[c] == ST_RUN);
  end

  assign oDone    = r_done;
  assign oSlot    = r_slot;
  assign oRdCount = r_count[iRdCh];

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus random traffic
// against a per-channel behavioural model.
module tb_count_sched;
  import count_sched_pkg::*;

  logic                  iClk = 1'b0;
  logic                  _iRst, _iLoad, _iHold;
  logic [CHW-1:0]        iLoadCh, iRdCh;
  logic [CountWidth-1:0] iLoadVal;
  logic [CountWidth-1:0] oRdCount;
  logic [NCH-1:0]        oBusy, oDone;
  logic [CHW-1:0]        oSlot;
`ifdef COUNT_SCHED_ABORT_EN
  logic                  _iAbort = 1'b1;
`endif

  always #5 iClk = ~iClk;

  count_sched dut (
    .iClk     (iClk),
    ._iRst    (_iRst),
    ._iLoad   (_iLoad),
    .iLoadCh  (iLoadCh),
    .iLoadVal (iLoadVal),
`ifdef COUNT_SCHED_ABORT_EN
    ._iAbort  (_iAbort),
`endif
    ._iHold   (_iHold),
    .iRdCh    (iRdCh),
    .oRdCount (oRdCount),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oSlot    (oSlot)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_seen [NCH];

  // behavioural model: counts, run flags, slot, and the one in-flight decrement
  int m_cnt  [NCH];
  bit m_run  [NCH];
  bit m_done [NCH];
  int m_slot;
  bit p_v;
  int p_ch, p_val;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_run[c] = 0; m_done[c] = 0;
    end
    m_slot = 0; p_v = 0; p_ch = 0; p_val = 0;
  endtask

  task automatic model_step();
    bit ld, ab, kill, nv;
    int kc, nch, nval;
    ld = !_iLoad;
    ab = 0;
`ifdef COUNT_SCHED_ABORT_EN
    ab = _iLoad && !_iAbort;
`endif
    kill = ld || ab;
    kc   = int'(iLoadCh);
    nv   = _iHold && m_run[m_slot] && !(kill && kc == m_slot);
    nch  = m_slot;
    nval = (m_cnt[m_slot] + 255) % 256;
    for (int c = 0; c < NCH; c++) m_done[c] = 0;
    if (p_v && !(kill && kc == p_ch)) begin
      m_cnt[p_ch] = p_val;
      if (p_val == 0) begin m_run[p_ch] = 0; m_done[p_ch] = 1; end
    end
    if (ld) begin
      m_cnt[kc]  = int'(iLoadVal);
      m_run[kc]  = (iLoadVal != 0);
      m_done[kc] = (iLoadVal == 0);
    end else if (ab) begin
      m_run[kc] = 0;
    end
    p_v = nv; p_ch = nch; p_val = nval;
    if (_iHold) m_slot = (m_slot + 1) % NCH;
  endtask

  task automatic check_outputs();
    int eb, ed;
    eb = 0; ed = 0;
    for (int c = 0; c < NCH; c++) begin
      eb |= int'(m_run[c]) << c;
      ed |= int'(m_done[c]) << c;
    end
    chk("busy", int'(oBusy), eb);
    chk("done", int'(oDone), ed);
    chk("slot", int'(oSlot), m_slot);
    chk("rdcount", int'(oRdCount), m_cnt[iRdCh]);
  endtask

  task automatic tick();
    @(posedge iClk);
    if (!_iRst) model_reset();
    else        model_step();
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) if (oDone[c]) done_seen[c]++;
    check_outputs();
  endtask

  task automatic clear_seen();
    for (int c = 0; c < NCH; c++) done_seen[c] = 0;
  endtask

  task automatic load(input int ch, input int val);
    _iLoad = 0; iLoadCh = CHW'(ch); iLoadVal = CountWidth'(val);
    tick();
    _iLoad = 1;
  endtask

  initial begin
    int load_cyc, first_done, saved_slot, saved_cnt;
    _iRst = 1; _iLoad = 0; _iHold = 1; iLoadCh = 1; iLoadVal = 7; iRdCh = 0;
    model_reset();
    clear_seen();
    #2 _iRst = 0;
    tick(); tick();
    #1 _iRst = 1;
    _iLoad = 1;
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_slot", int'(oSlot), 0);

    // ch1 = 3: busy from next cycle, exactly one done within the window
    clear_seen();
    iRdCh = 1;
    load_cyc = cyc;
    load(1, 3);
    chk("ch1_busy_next", int'(oBusy[1]), 1);
    chk("ch1_rd_start", int'(oRdCount), 3);
    first_done = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oDone[1] && first_done < 0) first_done = cyc;
    end
    chk("ch1_done_once", done_seen[1], 1);
    chk("ch1_done_window", int'(first_done >= load_cyc + 3 && first_done <= load_cyc + 14), 1);
    chk("ch1_rd_end", int'(oRdCount), 0);

    // load 0 -> single done pulse next cycle, never busy
    clear_seen();
    iRdCh = 2;
    load(2, 0);
    chk("ch2_zero_done", int'(oDone[2]), 1);
    chk("ch2_zero_busy", int'(oBusy[2]), 0);
    tick();
    chk("ch2_zero_done_off", int'(oDone[2]), 0);

    // reload ch0 in the cycle its 1->0 writeback lands
    clear_seen();
    iRdCh = 0;
    load(0, 1);
    for (int k = 0; k < 10 && !(p_v && p_ch == 0 && p_val == 0); k++) tick();
    chk("ch0_wb_found", int'(p_v && p_ch == 0 && p_val == 0), 1);
    load(0, 5);
    chk("ch0_reload_cnt", int'(oRdCount), 5);
    chk("ch0_reload_busy", int'(oBusy[0]), 1);
    chk("ch0_reload_nodone", done_seen[0], 0);
    for (int k = 0; k < 30; k++) tick();
    chk("ch0_reload_done", done_seen[0], 1);

    // all channels loaded with 2 back to back
    clear_seen();
    for (int c = 0; c < NCH; c++) load(c, 2);
    for (int k = 0; k < 20; k++) tick();
    for (int c = 0; c < NCH; c++) chk($sformatf("all2_done_ch%0d", c), done_seen[c], 1);

    // hold for 10 cycles with an entry in flight
    clear_seen();
    iRdCh = 3;
    load(3, 4);
    for (int k = 0; k < 10 && !(p_v && p_ch == 3); k++) tick();
    chk("hold_inflight", int'(p_v && p_ch == 3), 1);
    _iHold = 0;
    tick();
    saved_slot = int'(oSlot);
    saved_cnt  = int'(oRdCount);
    chk("hold_wb_landed", saved_cnt, 3);
    for (int k = 0; k < 9; k++) tick();
    chk("hold_slot_frozen", int'(oSlot), saved_slot);
    chk("hold_cnt_frozen", int'(oRdCount), saved_cnt);
    _iHold = 1;
    for (int k = 0; k < 20; k++) tick();
    chk("hold_resume_done", done_seen[3], 1);

`ifdef COUNT_SCHED_ABORT_EN
    clear_seen();
    load(3, 3);
    for (int k = 0; k < 10 && !(p_v && p_ch == 3); k++) tick();
    chk("abort_inflight", int'(p_v && p_ch == 3), 1);
    _iAbort = 0; iLoadCh = 3;
    tick();
    _iAbort = 1;
    chk("abort_busy", int'(oBusy[3]), 0);
    chk("abort_cnt", int'(oRdCount), 3);
    for (int k = 0; k < 20; k++) tick();
    chk("abort_nodone", done_seen[3], 0);
`endif

    // asynchronous reset mid-run
    load(1, 9);
    tick();
    #2 _iRst = 0;
    #1;
    chk("async_rst_busy", int'(oBusy), 0);
    chk("async_rst_slot", int'(oSlot), 0);
    tick();
    _iRst = 1;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      _iLoad   = ($urandom_range(0, 11) != 0);
      iLoadCh  = CHW'($urandom_range(0, NCH - 1));
      iLoadVal = ($urandom_range(0, 9) == 0) ? CountWidth'($urandom_range(0, 255))
                                             : CountWidth'($urandom_range(0, 6));
      _iHold   = ($urandom_range(0, 7) != 0);
      iRdCh    = CHW'($urandom_range(0, NCH - 1));
`ifdef COUNT_SCHED_ABORT_EN
      _iAbort  = ($urandom_range(0, 15) != 0);
`endif
      if ($urandom_range(0, 999) == 0) _iRst = 0;
      #1;
      tick();
      _iRst = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
